// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: default widths and FSM encoding.
package mult_share_arbiter_pkg;

   localparam int DW_DEF = 8;
   localparam int PW_DEF = 2 * DW_DEF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mult_share_arbiter_mult.sv
// The single shared unsigned multiplier: purely combinational, full-width product.
module mult_share_arbiter_mult
   import mult_share_arbiter_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic [DW-1:0]   d1,
   input  logic [DW-1:0]   d2,
   output logic [2*DW-1:0] out
);

   // Zero-extend both operands so the product is exact at 2*DW bits.
   assign out = {{DW{1'b0}}, d1} * {{DW{1'b0}}, d2};

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one multiplier among NREQ clients; registered operands
// and product, result returned with the owner's ID under valid/ready.
module mult_share_arbiter
   import mult_share_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = DW_DEF,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   d1_in,
   input  logic [NREQ*DW-1:0]   d2_in,
   output logic [NREQ-1:0]      gnt,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [2*DW-1:0]      res_out,
   output logic [IDW-1:0]       res_id,
   output logic                 busy
);

   state_t           state, state_nxt;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   id_q;
   logic [IDW-1:0]   win;
   logic             found;
   logic             take;
   logic [DW-1:0]    op_a, op_b;
   logic [2*DW-1:0]  prod;

   // Returns {found, index}. Scanning offsets from farthest to nearest lets the
   // requester closest after p overwrite every other candidate.
   function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IDW-1:0]  p);
      logic [IDW:0] res;
      int           idx;
      res = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(p) + k) % NREQ;
         if (r[idx]) res = {1'b1, IDW'(idx)};
      end
      return res;
   endfunction

   assign {found, win} = rr_pick(req, ptr);

   // Reset masks the grant so nothing is offered while the block is being cleared.
   assign take = (state == S_IDLE) && found && !rst;
   assign busy = (state != S_IDLE);

   always_comb begin
      gnt = '0;
      if (take) gnt[win] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (take) state_nxt = S_MUL;
         S_MUL:   state_nxt = S_DONE;
         S_DONE:  if (res_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   mult_share_arbiter_mult #(.DW(DW)) u_mult (
      .d1  (op_a),
      .d2  (op_b),
      .out (prod)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= IDW'(NREQ - 1);
         id_q      <= '0;
         op_a      <= '0;
         op_b      <= '0;
         res_out   <= '0;
         res_id    <= '0;
         res_valid <= 1'b0;
      end else begin
         if (take) begin
            op_a <= d1_in[win*DW +: DW];
            op_b <= d2_in[win*DW +: DW];
            id_q <= win;
            ptr  <= win;
         end
         if (state == S_MUL) begin
            res_out   <= prod;
            res_id    <= id_q;
            res_valid <= 1'b1;
         end
         if (state == S_DONE && res_ready) res_valid <= 1'b0;
      end
   end

endmodule
